// File: rtl/bubble_sort.sv
// bubble_sort: serial-in/serial-out bubble sorter for a frame of N signed words.
// Optional early exit on a swap-free pass: define BUBBLE_SORT_EARLY_EXIT_EN.
module bubble_sort #(
    parameter int N     = 10,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_serial_i,
    output logic [WIDTH-1:0] data_serial_o,
    output logic             ready_o
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] ONE    = IW'(1);
    localparam logic [IW-1:0] LAST_J = IW'(N - 2);
    localparam logic [IW-1:0] LAST_W = IW'(N - 1);

    typedef enum logic [1:0] {LOAD, SORT, OUT, DONE} state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           pass_q;
    logic signed [WIDTH-1:0] mem_q [N];
    logic [IW-1:0]           idx_d;
    logic                    swap_d;
    logic                    pass_end_d;
    logic                    sort_done_d;

    assign idx_d      = idx_q + ONE;
    assign swap_d     = (state_q == SORT) && (mem_q[idx_q] > mem_q[idx_d]);
    assign pass_end_d = idx_q == LAST_J;

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    logic swapped_q;

    // Remember whether the current pass has swapped anything so far
    always_ff @(posedge clk) begin
        if (!rst || state_q != SORT)
            swapped_q <= 1'b0;
        else
            swapped_q <= pass_end_d ? 1'b0 : (swapped_q | swap_d);
    end

    assign sort_done_d = pass_end_d && ((pass_q == LAST_J) || !(swapped_q || swap_d));
`else
    assign sort_done_d = pass_end_d && (pass_q == LAST_J);
`endif

    // Frame FSM: load words, compare-swap one pair per cycle, stream out sorted words
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= LOAD;
            idx_q         <= '0;
            pass_q        <= '0;
            data_serial_o <= '0;
            ready_o       <= 1'b0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    mem_q[idx_q] <= data_serial_i;
                    idx_q        <= (idx_q == LAST_W) ? '0 : idx_d;
                    if (idx_q == LAST_W) state_q <= SORT;
                end
                SORT: begin
                    if (swap_d) begin
                        mem_q[idx_q] <= mem_q[idx_d];
                        mem_q[idx_d] <= mem_q[idx_q];
                    end
                    idx_q  <= pass_end_d ? '0 : idx_d;
                    pass_q <= sort_done_d ? '0 : (pass_end_d ? pass_q + ONE : pass_q);
                    if (sort_done_d) state_q <= OUT;
                end
                OUT: begin
                    data_serial_o <= mem_q[idx_q];
                    ready_o       <= 1'b1;
                    idx_q         <= (idx_q == LAST_W) ? '0 : idx_d;
                    if (idx_q == LAST_W) state_q <= DONE;
                end
                DONE: begin
                    ready_o <= 1'b0;
                    state_q <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_bubble_sort.sv
// tb_bubble_sort: randomized and directed frames checked against a sorting reference model.
module tb_bubble_sort;
    localparam int N = 10;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         rdy;
    int           vectors = 0;
    int           miscompares = 0;
    logic signed [W-1:0] fr  [N];
    logic signed [W-1:0] srt [N];

    bubble_sort #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_serial_i(din), .data_serial_o(dout), .ready_o(rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: stable ascending signed order by insertion
    task automatic prep();
        logic signed [W-1:0] v;
        int k;
        srt = fr;
        for (int i = 1; i < N; i++) begin
            v = srt[i];
            k = i - 1;
            while (k >= 0 && srt[k] > v) begin
                srt[k+1] = srt[k];
                k--;
            end
            srt[k+1] = v;
        end
    endtask

    // Edges from last capture to first output word
    function automatic int exp_latency();
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        int mx = 0;
        int c;
        int passes;
        for (int i = 0; i < N; i++) begin
            c = 0;
            for (int j = 0; j < i; j++) if (fr[j] > fr[i]) c++;
            if (c > mx) mx = c;
        end
        passes = (mx + 1 > N - 1) ? N - 1 : mx + 1;
        return passes * (N - 1) + 1;
`else
        return (N - 1) * (N - 1) + 1;
`endif
    endfunction

    task automatic load_frame();
        for (int k = 0; k < N; k++) begin
            din = fr[k];
            @(posedge clk); #1;
            check("load_rdy", W'(rdy), '0);
        end
    endtask

    task automatic run_frame(input string name);
        int lat = 0;
        prep();
        load_frame();
        while (!rdy && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, W'(lat), W'(exp_latency()));
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check({name, "_rdy"}, W'(rdy), W'(1));
            check($sformatf("%s_word%0d", name, i), dout, srt[i]);
        end
        @(posedge clk); #1;
        check({name, "_rdy_fall"}, W'(rdy), '0);
        check({name, "_hold"}, dout, srt[N-1]);
    endtask

    task automatic random_frame(input bit narrow);
        for (int k = 0; k < N; k++)
            fr[k] = narrow ? W'($signed($urandom_range(0, 6)) - 3) : W'($urandom);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", W'(rdy), '0);
        check("reset_dout", dout, '0);
        rst = 1'b1;

        fr = '{570, -347, 0, 383, -347, -881, 203, -281, 797, 345};
        run_frame("mixed");
        for (int k = 0; k < N; k++) fr[k] = 570;
        run_frame("equal");
        for (int k = 0; k < N; k++) fr[k] = W'(9 - k);
        run_frame("reverse");
        for (int k = 0; k < N; k++) fr[k] = W'(k);
        run_frame("ascending");
        fr = '{32'h7FFFFFFF, 32'h80000000, -1, 0, 1,
               32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        run_frame("extremes");

        random_frame(1'b0);
        load_frame();
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midsort_rdy", W'(rdy), '0);
        check("midsort_dout", dout, '0);
        for (int i = 0; i < N; i++) check($sformatf("midsort_mem%0d", i), dut.mem_q[i], '0);
        rst = 1'b1;

        for (int f = 0; f < 6; f++) begin
            random_frame(f[0]);
            run_frame($sformatf("rand%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bubble_sort.md
Name: bubble_sort

Overview:
- Serial-in/serial-out sorter for a frame of N signed words.
- Phases: LOAD captures N words, one per cycle; SORT runs a bubble sort in internal registers, one compare-swap per cycle; OUTPUT streams the words back in ascending signed order, one per cycle, with a ready flag.
- Used as a standalone accelerator block fed by a serial word stream.

Parameters:
- N, 10, number of words per frame (N >= 2).
- WIDTH, 32, word width in bits; words are two's-complement signed.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-low reset (sampled on the clk rising edge; 0 = reset).
- data_serial_i  input  WIDTH  signed input word, sampled once per cycle during LOAD.
- data_serial_o  output  WIDTH  signed output word, registered; valid while ready_o = 1.
- ready_o  output  1  registered; high exactly during the N OUTPUT cycles.

Behaviour:
- Reset (rst = 0 at an edge):
  - State goes to LOAD; load index, pass and compare counters clear to 0.
  - All N storage words clear to 0; data_serial_o = 0; ready_o = 0.
  - Reset overrides everything and aborts any frame mid-operation.
- Cycle numbering: edge 0 is the first rising edge with rst = 1.
- LOAD (edges 0..N-1):
  - Edge k writes data_serial_i into mem[k].
  - At edge N-1 the state moves to SORT.
  - data_serial_o is held at 0 and ready_o = 0.
- SORT:
  - Pass counter p runs 0..N-2; compare index j runs 0..N-2.
  - Each edge compares mem[j] with mem[j+1] as signed WIDTH-bit values.
  - Swap only when mem[j] > mem[j+1] (strict), so equal values never swap and the sort is stable.
  - j increments each edge; when j = N-2, j wraps to 0 and p increments.
  - Fixed length: (N-1)*(N-1) edges (81 for N = 10), i.e. edges N..N+(N-1)^2-1.
  - data_serial_i is ignored; ready_o = 0.
- OUTPUT:
  - On the edge after the final compare (edge N+(N-1)^2), data_serial_o <= mem[0] and ready_o <= 1.
  - Each following edge presents the next word, mem[1]..mem[N-1]; ready_o stays high for exactly N cycles.
  - Words come out ascending: most negative first, duplicates adjacent.
- Return to LOAD:
  - On the edge after the last word, ready_o <= 0, data_serial_o holds its last value, and the state returns to LOAD with counters at 0.
  - The next frame's first word is captured on the following edge; storage is not cleared, and new words overwrite it.
- Latency: first output appears (N-1)^2 + 1 cycles after the edge that captured the last input word (82 for N = 10).
- Arithmetic: comparison is full-width signed, with no saturation or truncation.
- Input X during LOAD is stored as-is; no validity input exists, so every LOAD cycle captures.

Optional Feature:
- Macro: BUBBLE_SORT_EARLY_EXIT_EN.
- Defined:
  - A swap flag is cleared at the start of each pass and set on any swap.
  - If a pass completes with no swap, SORT ends immediately and OUTPUT begins on the next edge.
  - Latency becomes variable: an already-sorted frame enters OUTPUT after N-1 compare cycles.
  - Output ordering and the OUTPUT/ready_o rules are unchanged.
- Undefined: fixed (N-1)^2-cycle SORT as above; no swap flag logic is synthesised.

Test Plan:
- Mixed frame 570, -347, 0, 383, -347, -881, 203, -281, 797, 345 loaded from edge 0 -> ready_o rises 82 cycles after the last capture and outputs are -881, -347, -347, -281, 0, 203, 345, 383, 570, 797 (hex FFFFFC8F, FFFFFEA5, FFFFFEA5, FFFFFEE7, 00000000, 000000CB, 00000159, 0000017F, 0000023A, 0000031D), then ready_o falls.
- All ten words = 570 (0x0000023A) -> ten outputs of 570; ready_o high exactly 10 cycles.
- Reverse order 9..0 -> outputs 0..9; with BUBBLE_SORT_EARLY_EXIT_EN, ascending input 0..9 -> OUTPUT begins 10 cycles after the last capture (9 compares plus 1 transition edge).
- Extremes 0x7FFFFFFF, 0x80000000, -1, 0, 1 plus five copies of 0x80000000 -> signed order with 0x80000000 first and 0x7FFFFFFF last.
- rst = 0 asserted for one edge mid-SORT -> ready_o = 0, data_serial_o = 0, all storage 0; a fresh frame then sorts correctly with nominal latency.
- Two back-to-back frames without reset -> the second frame's capture starts one edge after ready_o falls and its output is correct.
